// File: rtl/game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : game_pkg                                                   |
// | Description : Shared types and default timing for the game input stage.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package game_pkg;

  // Per-channel debounce/hold state
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHK_PRESS = 2'd1,
    HELD      = 2'd2,
    CHK_REL   = 2'd3
  } ch_state_e;

  // Channel indices into the button/held vectors
  localparam int unsigned CH_RIGHT   = 0;
  localparam int unsigned CH_LEFT    = 1;
  localparam int unsigned CH_RESTART = 2;
  localparam int unsigned NUM_CH     = 3;

  // Default timing for a 12 MHz clock
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 240000;   // 20 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 6000000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_PERIOD   = 1800000;  // 150 ms
  localparam int unsigned DEF_CNT_W           = 23;

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : btn_channel                                                |
// | Description : One button: synchroniser, debounce FSM and optional        |
// |               auto-repeat. Emits a registered one-cycle strobe.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module btn_channel
  import game_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic strobe_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_deb        = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_rpt_delay  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] c_rpt_period = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] c_cnt_max    = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_pressed;

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  // first_q: still waiting for the first (longer) repeat interval
  logic             first_q, first_d;
  logic             strobe_q, strobe_d;

  // Input synchroniser; resets to the released (high) level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
    end
  end

  assign sync_pressed = ~sync_q[SYNC_STAGES-1];

  // Debounce/repeat next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rpt_d    = rpt_q;
    first_d  = first_q;
    strobe_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_pressed) begin
          state_d = CHK_PRESS;
          cnt_d   = c_one;
        end
      end
      CHK_PRESS: begin
        if (!sync_pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == c_deb) begin
          state_d  = HELD;
          strobe_d = 1'b1;
          rpt_d    = c_one;
          first_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      HELD: begin
        if (!sync_pressed) begin
          state_d = CHK_REL;
          cnt_d   = c_one;
        end else if (REPEAT_EN) begin
          if ((first_q && (rpt_q == c_rpt_delay)) ||
              (!first_q && (rpt_q == c_rpt_period))) begin
            strobe_d = 1'b1;
            rpt_d    = c_one;
            first_d  = 1'b0;
          end else if (rpt_q != c_cnt_max) begin
            rpt_d = rpt_q + c_one;
          end
        end
      end
      CHK_REL: begin
        if (sync_pressed) begin
          // Release bounce: back to held, repeat timing starts over
          state_d = HELD;
          rpt_d   = c_one;
          first_d = 1'b1;
        end else if (cnt_q == c_deb) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, counters and strobe register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rpt_q    <= '0;
      first_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rpt_q    <= rpt_d;
      first_q  <= first_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;
  assign held_o   = (state_q == HELD) || (state_q == CHK_REL);

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : button_conditioner                                         |
// | Description : Debounced, auto-repeating press pulses for the three game  |
// |               buttons, with left/right conflict suppression.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module button_conditioner
  import game_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_1_i,
  input  logic       btn_2_i,
  input  logic       btn_rst_i,
  output logic       right_pulse_o,
  output logic       left_pulse_o,
  output logic       restart_pulse_o,
  output logic [2:0] btn_held_o
);

  logic [NUM_CH-1:0] btn_n;
  logic [NUM_CH-1:0] strobe;
  logic [NUM_CH-1:0] held;

  logic right_d, left_d;
  logic right_q, left_q, restart_q;
  logic [NUM_CH-1:0] held_q;

  assign btn_n = {btn_rst_i, btn_2_i, btn_1_i};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .CNT_W          (CNT_W),
      .REPEAT_EN      (g != CH_RESTART)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_n_i (btn_n[g]),
      .strobe_o(strobe[g]),
      .held_o  (held[g])
    );
  end

  // Opposing move requests in the same cycle cancel each other
  always_comb begin
    right_d = strobe[CH_RIGHT] & ~strobe[CH_LEFT];
    left_d  = strobe[CH_LEFT]  & ~strobe[CH_RIGHT];
  end

  // Output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      right_q   <= 1'b0;
      left_q    <= 1'b0;
      restart_q <= 1'b0;
      held_q    <= '0;
    end else begin
      right_q   <= right_d;
      left_q    <= left_d;
      restart_q <= strobe[CH_RESTART];
      held_q    <= held;
    end
  end

  assign right_pulse_o   = right_q;
  assign left_pulse_o    = left_q;
  assign restart_pulse_o = restart_q;
  assign btn_held_o      = held_q;

endmodule
`default_nettype wire
